// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_pkg
// Description : Shared UART parameters. Holds the receiver defaults, the
//               command-decoder FSM encoding, the error codes and the frame
//               start marker.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_decoder_pkg;

    // Receiver and config-bus defaults
    localparam int         C_UART_DATABITS_DEFAULT  = 8;
    localparam int         C_CFG_ADDR_W_DEFAULT     = 4;
    localparam int         C_CFG_DATA_W_DEFAULT     = 8;
    localparam int         C_TIMEOUT_CYCLES_DEFAULT = 100000;

    // Frame start marker
    localparam logic [7:0] C_SYNC_BYTE_DEFAULT      = 8'hA5;

    // Command decoder FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_SEND = 3'd4
    } dec_state_t;

    // Error codes reported on err_code
    typedef logic [2:0] err_code_t;
    localparam err_code_t C_ERR_NONE     = 3'd0;
    localparam err_code_t C_ERR_LINE     = 3'd1;
    localparam err_code_t C_ERR_CHECKSUM = 3'd2;
    localparam err_code_t C_ERR_TIMEOUT  = 3'd3;
    localparam err_code_t C_ERR_OVERRUN  = 3'd4;
    localparam err_code_t C_ERR_BAD_ADDR = 3'd5;

    // Saturating increment for the 8-bit error counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_if
// Description : Receiver-side byte stream, config bus and error reporting
//               signals of the UART command decoder. The decoder uses the
//               master modport; its environment uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if
    import uart_cmd_decoder_pkg::*;
#(
    parameter int WIDTH_DATABITS    = C_UART_DATABITS_DEFAULT,
    parameter int WIDTH_CONFIG_ADDR = C_CFG_ADDR_W_DEFAULT,
    parameter int WIDTH_CONFIG_DATA = C_CFG_DATA_W_DEFAULT
);

    // UART receiver side
    logic [WIDTH_DATABITS-1:0]    rx_data;
    logic                         rx_valid;
    logic                         rx_error;

    // Config bus
    logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
    logic [WIDTH_CONFIG_DATA-1:0] c_data;
    logic                         c_valid;
    logic                         c_ready;

    // Error reporting
    logic [2:0]                   err_code;
    logic                         err_valid;
    logic [7:0]                   err_count;

    modport master (
        input  rx_data, rx_valid, rx_error, c_ready,
        output c_addr, c_data, c_valid, err_code, err_valid, err_count
    );

    modport slave (
        output rx_data, rx_valid, rx_error, c_ready,
        input  c_addr, c_data, c_valid, err_code, err_valid, err_count
    );

endinterface
`default_nettype wire

// File: rtl/uart_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_gap_timer
// Description : Inter-byte gap counter. Counts enabled cycles since the last
//               clear and flags expiry once TIMEOUT_CYCLES-1 is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int                 C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_count;

    // Counter is held at zero while disabled or cleared and stops at the last value
    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            r_count <= '0;
        end else if (r_count != C_LAST) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign expired = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Decodes SYNC/ADDR/DATA/CHK frames from a UART receiver into
//               config-bus writes, reporting line, checksum, timeout,
//               overrun and bad-address errors with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int                        WIDTH_DATABITS    = C_UART_DATABITS_DEFAULT,
    parameter int                        WIDTH_CONFIG_ADDR = C_CFG_ADDR_W_DEFAULT,
    parameter int                        WIDTH_CONFIG_DATA = C_CFG_DATA_W_DEFAULT,
    parameter logic [WIDTH_DATABITS-1:0] SYNC_BYTE         = WIDTH_DATABITS'(C_SYNC_BYTE_DEFAULT),
    parameter int                        TIMEOUT_CYCLES    = C_TIMEOUT_CYCLES_DEFAULT
) (
    input wire logic              clk,
    input wire logic              rst,
    uart_cmd_decoder_if.master    bus
);

    dec_state_t                   r_state;
    dec_state_t                   w_state_nxt;

    logic [WIDTH_DATABITS-1:0]    r_addr_byte;
    logic [WIDTH_DATABITS-1:0]    r_data_byte;

    logic                         w_in_frame;
    logic                         w_byte;
    logic                         w_line_err;
    logic                         w_timer_clear;
    logic                         w_timer_expired;
    logic                         w_timeout;
    logic                         w_chk_ok;
    logic                         w_addr_ok;

    logic                         w_err_fire;
    err_code_t                    w_err_code;
    logic                         w_load_tx;

    logic                         r_c_valid;
    logic [WIDTH_CONFIG_ADDR-1:0] r_c_addr;
    logic [WIDTH_CONFIG_DATA-1:0] r_c_data;
    logic                         r_err_valid;
    err_code_t                    r_err_code;
    logic [7:0]                   r_err_count;

    // A line error masks a byte delivered in the same cycle
    assign w_line_err = bus.rx_error;
    assign w_byte     = bus.rx_valid && !bus.rx_error;

    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CHK);

    // Any receiver activity restarts the gap; outside a frame the counter idles at zero
    assign w_timer_clear = !w_in_frame || bus.rx_valid || bus.rx_error;

    uart_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (w_in_frame),
        .expired (w_timer_expired)
    );

    // A byte arriving on the expiry cycle still counts, so only a silent cycle times out
    assign w_timeout = w_timer_expired && !bus.rx_valid && !bus.rx_error;

    assign w_chk_ok  = (bus.rx_data == (r_addr_byte ^ r_data_byte));
    assign w_addr_ok = ((r_addr_byte >> WIDTH_CONFIG_ADDR) == '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, error detection and transaction load decode
    always_comb begin
        w_state_nxt = r_state;
        w_err_fire  = 1'b0;
        w_err_code  = C_ERR_NONE;
        w_load_tx   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_line_err) begin
                    w_err_fire = 1'b1;
                    w_err_code = C_ERR_LINE;
                end else if (w_byte && (bus.rx_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR, ST_DATA: begin
                if (w_line_err) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = C_ERR_LINE;
                    w_state_nxt = ST_IDLE;
                end else if (w_byte) begin
                    w_state_nxt = (r_state == ST_ADDR) ? ST_DATA : ST_CHK;
                end else if (w_timeout) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = C_ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_CHK: begin
                if (w_line_err) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = C_ERR_LINE;
                    w_state_nxt = ST_IDLE;
                end else if (w_byte) begin
                    // Checksum failure outranks an out-of-range address
                    if (!w_chk_ok) begin
                        w_err_fire  = 1'b1;
                        w_err_code  = C_ERR_CHECKSUM;
                        w_state_nxt = ST_IDLE;
                    end else if (!w_addr_ok) begin
                        w_err_fire  = 1'b1;
                        w_err_code  = C_ERR_BAD_ADDR;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load_tx   = 1'b1;
                        w_state_nxt = ST_SEND;
                    end
                end else if (w_timeout) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = C_ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SEND: begin
                // Receiver events are reported but never abort a pending write
                if (w_line_err) begin
                    w_err_fire = 1'b1;
                    w_err_code = C_ERR_LINE;
                end else if (bus.rx_valid) begin
                    w_err_fire = 1'b1;
                    w_err_code = C_ERR_OVERRUN;
                end
                if (r_c_valid && bus.c_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the address and data bytes as the frame advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_byte <= '0;
            r_data_byte <= '0;
        end else begin
            if ((r_state == ST_ADDR) && w_byte) begin
                r_addr_byte <= bus.rx_data;
            end
            if ((r_state == ST_DATA) && w_byte) begin
                r_data_byte <= bus.rx_data;
            end
        end
    end

    // Config bus outputs: valid tracks SEND, address/data frozen on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_addr  <= '0;
            r_c_data  <= '0;
        end else begin
            r_c_valid <= (w_state_nxt == ST_SEND);
            if (w_load_tx) begin
                r_c_addr <= WIDTH_CONFIG_ADDR'(r_addr_byte);
                r_c_data <= WIDTH_CONFIG_DATA'(r_data_byte);
            end
        end
    end

    // Error strobe, sticky code and saturating count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_code  <= C_ERR_NONE;
            r_err_count <= 8'd0;
        end else begin
            r_err_valid <= w_err_fire;
            if (w_err_fire) begin
                r_err_code  <= w_err_code;
                r_err_count <= sat_inc8(r_err_count);
            end
        end
    end

    assign bus.c_valid   = r_c_valid;
    assign bus.c_addr    = r_c_addr;
    assign bus.c_data    = r_c_data;
    assign bus.err_valid = r_err_valid;
    assign bus.err_code  = r_err_code;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH_DATABITS, default 8, meaning received byte width.
REQ-002 The block SHALL have parameter WIDTH_CONFIG_ADDR, default 4, meaning config bus address width.
REQ-003 The block SHALL have parameter WIDTH_CONFIG_DATA, default 8, meaning config bus data width.
REQ-004 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum clk cycles allowed between bytes inside a frame.
REQ-006 Ports, listed as name direction width meaning; one clock, reset synchronous and active-high:
- clk  in  1  system clock, the same clock as the UART receiver
- rst  in  1  synchronous active-high reset
- rx_data  in  WIDTH_DATABITS  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_error  in  1  one-cycle strobe, receiver framing/parity error
- c_addr  out  WIDTH_CONFIG_ADDR  config address
- c_data  out  WIDTH_CONFIG_DATA  config data
- c_valid  out  1  config transaction valid
- c_ready  in  1  config bus free
- err_code  out  3  1=line, 2=checksum, 3=timeout, 4=overrun, 5=bad address
- err_valid  out  1  one-cycle error strobe
- err_count  out  8  saturating error counter

Function
REQ-007 The frame format SHALL be SYNC_BYTE, ADDR byte, DATA byte, CHK byte, with CHK = ADDR xor DATA.
REQ-008 The FSM SHALL have states IDLE, ADDR, DATA, CHK and SEND.
REQ-009 In IDLE, an rx_valid with rx_data==SYNC_BYTE SHALL move the FSM to ADDR; any other byte SHALL be discarded silently.
REQ-010 Each rx_valid SHALL advance ADDR->DATA->CHK, latching the byte, and SHALL reload the gap counter to 0.
REQ-011 In CHK, a byte equal to ADDR xor DATA SHALL move the FSM to SEND; a mismatch SHALL raise err_code 2 and move the FSM to IDLE.
REQ-012 An ADDR byte with bits [7:WIDTH_CONFIG_ADDR] nonzero SHALL raise err_code 5 at CHK time instead of entering SEND; the checksum error has priority.
REQ-013 In SEND, c_valid SHALL be 1, with c_addr and c_data stable, until the cycle c_valid&&c_ready; the FSM SHALL then go to IDLE on the next edge.
REQ-014 Latency SHALL be one cycle: c_valid rises on the clk edge after the CHK byte strobe.
REQ-015 An rx_valid while in SEND SHALL be dropped and raise err_code 4; SEND SHALL continue.
REQ-016 An rx_error in any state SHALL raise err_code 1; in ADDR, DATA or CHK the FSM SHALL abort to IDLE; in SEND it SHALL not abort.
REQ-017 In ADDR, DATA or CHK, a gap counter reaching TIMEOUT_CYCLES-1 without rx_valid SHALL raise err_code 3 and return the FSM to IDLE.
REQ-018 In IDLE and SEND the gap counter SHALL be held at 0.
REQ-019 If rx_valid and rx_error occur in the same cycle, rx_error SHALL win and the byte SHALL be ignored.
REQ-020 err_valid SHALL be a one-cycle pulse registered one cycle after the causing event; err_code SHALL hold its last value.
REQ-021 err_count SHALL increment on every err_valid and saturate at 255.

Reset
REQ-022 On rst=1 at a clk edge: FSM=IDLE; c_valid=0, c_addr=0, c_data=0, err_valid=0, err_code=0, err_count=0; gap counter=0.
REQ-023 A reset during SEND SHALL drop the pending transaction with no error.

Structure
REQ-024 The FSM state encoding, the error code constants and the SYNC_BYTE default SHALL be placed in the shared UART parameters include alongside the existing UART parameters.
REQ-025 The gap counter SHALL be one sub-module, uart_gap_timer (inputs clear and enable; output expired), with width $clog2(TIMEOUT_CYCLES).

Verification
REQ-026 Frame A5,03,5A,59 with c_ready=1 -> one c_valid pulse, c_addr=3, c_data=8'h5A, one cycle after the CHK strobe; err_count=0.
REQ-027 Frame A5,03,5A,00 -> err_valid with err_code=2, no c_valid, FSM back in IDLE.
REQ-028 Valid frame with c_ready=0 for 10 cycles, plus byte 8'h11 arriving during the wait -> c_valid held 10 cycles with stable addr/data, err_code=4; the transaction completes when c_ready=1.
REQ-029 A5,03 then silence for TIMEOUT_CYCLES (parameter set to 16) -> err_code=3 at cycle 16; a following clean frame decodes correctly.
REQ-030 rx_error during DATA, and rx_valid+rx_error in the same cycle -> err_code=1 each time, abort to IDLE; 300 injected errors -> err_count=255.
